// File: rtl/cache_pkg.sv
// Shared widths and address-field helpers for the direct-mapped read-only cache.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int LINES_DEF     = 16;
  localparam int WPL_DEF       = 4;
  localparam int MEM_WORDS_DEF = 1024;

  localparam int OFFSET_W = $clog2(WPL_DEF);
  localparam int INDEX_W  = $clog2(LINES_DEF);
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W - 2;

  // Field widths are passed in so non-default geometries share the same helpers.
  function automatic logic [ADDR_W-1:0] addr_offset(input logic [ADDR_W-1:0] a, input int ow);
    return (a >> 2) & ((ADDR_W'(1) << ow) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a, input int ow,
                                                   input int iw);
    return (a >> (2 + ow)) & ((ADDR_W'(1) << iw) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int ow,
                                                 input int iw);
    return a >> (2 + ow + iw);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] a, input int maw);
    return (a >> 2) & ((ADDR_W'(1) << maw) - ADDR_W'(1));
  endfunction
endpackage

// File: rtl/cache_backing_mem.sv
// Read-only backing store (word i holds i); returns every word of one block.
module cache_backing_mem
  import cache_pkg::*;
#(
  parameter int MEM_WORDS      = MEM_WORDS_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF
) (
  input  logic [$clog2(MEM_WORDS)-1:0]          base_idx,
  output logic [WORDS_PER_LINE-1:0][DATA_W-1:0] words
);
  localparam int MAW = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_comb begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = DATA_W'(i);
  end

  // base_idx is block-aligned, so base + w never crosses the memory end.
  always_comb begin
    for (int w = 0; w < WORDS_PER_LINE; w++) words[w] = mem[base_idx + MAW'(w)];
  end
endmodule

// File: rtl/cache.sv
// Direct-mapped read-only cache: one lookup per clock, misses fill the line in the same edge.
module cache
  import cache_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF,
  parameter int MEM_WORDS      = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Hit_Miss
);
  localparam int OW  = $clog2(WORDS_PER_LINE);
  localparam int IW  = $clog2(LINES);
  localparam int TW  = ADDR_W - OW - IW - 2;
  localparam int MAW = $clog2(MEM_WORDS);

  logic [LINES-1:0]                                 valid_q;
  logic [LINES-1:0][TW-1:0]                         tag_q;
  logic [LINES-1:0][WORDS_PER_LINE-1:0][DATA_W-1:0] line_q;
  logic [DATA_W-1:0]                                data_out_d, data_out_q;
  logic                                             hit_miss_d, hit_miss_q;

  logic [OW-1:0]                          off;
  logic [IW-1:0]                          idx;
  logic [TW-1:0]                          tag;
  logic [MAW-1:0]                         blk_base;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  blk_words;

  always_comb begin
    off      = OW'(addr_offset(Address, OW));
    idx      = IW'(addr_index(Address, OW, IW));
    tag      = TW'(addr_tag(Address, OW, IW));
    blk_base = MAW'(addr_word(Address, MAW)) & ~MAW'(WORDS_PER_LINE - 1);
  end

  cache_backing_mem #(
    .MEM_WORDS      (MEM_WORDS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_mem (
    .base_idx (blk_base),
    .words    (blk_words)
  );

  always_comb begin
    hit_miss_d = valid_q[idx] && (tag_q[idx] == tag);
    data_out_d = hit_miss_d ? line_q[idx][off] : blk_words[off];
  end

  // Tag/data arrays are only qualified by valid, so reset clears just the valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      hit_miss_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      hit_miss_q <= hit_miss_d;
      data_out_q <= data_out_d;
      if (!hit_miss_d) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
        line_q[idx]  <= blk_words;
      end
    end
  end

  assign Data_Out = data_out_q;
  assign Hit_Miss = hit_miss_q;
endmodule

// File: tb/tb_cache.sv
// Scoreboarded random + directed bench for cache against an address-arithmetic model.
module tb_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] Data_Out;
  logic        Hit_Miss;

  cache dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Address  (Address),
    .Data_Out (Data_Out),
    .Hit_Miss (Hit_Miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   done   = 0;

  // Reference model: which block (tag) each line currently holds.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];

  task automatic step(input logic [31:0] a, input logic r);
    exp_t e;
    int   idx;
    @(negedge clk);
    Address = a;
    rst_n   = r;
    @(posedge clk);
    e.addr = a;
    if (!r) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      e.hit  = 1'b0;
      e.data = 32'h0;
    end else begin
      idx    = int'((a >> 4) % 16);
      e.hit  = m_valid[idx] && (m_tag[idx] == (a >> 8));
      e.data = (a >> 2) % 1024;
      m_valid[idx] = 1;
      m_tag[idx]   = a >> 8;
    end
    q.push_back(e);
  endtask

  // Monitor: one registered output per clock, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (Hit_Miss === e.hit && Data_Out === e.data) passes++;
        else $display("FAIL lookup addr=%h got hit=%b data=%h want hit=%b data=%h",
                      e.addr, Hit_Miss, Data_Out, e.hit, e.data);
      end
    end
  end

  initial begin
    logic [31:0] tags [5];
    logic [31:0] a;
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h10; tags[3] = 32'hFFFFFF; tags[4] = 32'h7;
    rst_n   = 1'b0;
    Address = 32'h0;
    foreach (m_valid[i]) m_valid[i] = 0;

    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    // Repeated address, then same-block neighbours
    step(32'h8, 1'b1); step(32'h8, 1'b1); step(32'h8, 1'b1);
    step(32'hC, 1'b1); step(32'h0, 1'b1); step(32'h4, 1'b1);
    // Conflict on index 0
    step(32'h8, 1'b1); step(32'h108, 1'b1); step(32'h8, 1'b1); step(32'h8, 1'b1);
    // Memory-wrap alias
    step(32'h1008, 1'b1); step(32'h8, 1'b1);
    // Byte bits ignored
    step(32'h9, 1'b1); step(32'hA, 1'b1); step(32'hB, 1'b1);
    // Reset mid-run
    step(32'h8, 1'b1); step(32'h8, 1'b0); step(32'h8, 1'b1); step(32'h8, 1'b1);

    for (int n = 0; n < 600; n++) begin
      a = (tags[$urandom_range(4)] << 8) | 32'($urandom_range(255));
      if ($urandom_range(7) == 0) a = $urandom;
      step(a, ($urandom_range(63) == 0) ? 1'b0 : 1'b1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain pending=%0d want 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1);
  end
endmodule
